reg_scoreboard: RTL

- Issue-stage scoreboard for the Minisys-1A pipeline. It tracks outstanding writes to the 32 general registers and the HI/LO pair, and sequences the multi-cycle multiply/divide unit (MDU).
- Sits beside the ID-stage register file. It consumes decoded source/destination fields from ID and write-back events from WB, and raises a stall so ID never reads a register with a pending write.

---
 rtl/reg_scoreboard_if.sv | 52 +++++
 rtl/reg_scoreboard.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard_if.sv
// ID/WB-side bundle of the issue-stage scoreboard. With SB_STATS_EN defined it
// also carries the stall_cycles / issue_count statistics outputs.
interface reg_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_wen;
  logic [4:0]  id_waddr;
  logic        id_hilo_rd;
  logic        id_mdu_start;
  logic        id_mdu_div;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic        stall;
  logic        issue;
  logic [31:0] busy_vec;
  logic        hilo_busy;
  logic        mdu_done;
  logic        sb_err;
`ifdef SB_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] issue_count;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_waddr,
           id_hilo_rd, id_mdu_start, id_mdu_div, wb_wen, wb_waddr,
    input  stall, issue, busy_vec, hilo_busy, mdu_done, sb_err,
           stall_cycles, issue_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_waddr,
           id_hilo_rd, id_mdu_start, id_mdu_div, wb_wen, wb_waddr,
    output stall, issue, busy_vec, hilo_busy, mdu_done, sb_err,
           stall_cycles, issue_count
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_waddr,
           id_hilo_rd, id_mdu_start, id_mdu_div, wb_wen, wb_waddr,
    input  stall, issue, busy_vec, hilo_busy, mdu_done, sb_err
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_waddr,
           id_hilo_rd, id_mdu_start, id_mdu_div, wb_wen, wb_waddr,
    output stall, issue, busy_vec, hilo_busy, mdu_done, sb_err
  );
`endif
endinterface

// File: rtl/reg_scoreboard.sv
// Issue-stage scoreboard: pending-write counters for GPRs and HI/LO/MDU sequencing.
// Optional statistics counters are built when SB_STATS_EN is defined.
module reg_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 32
) (
  input  logic           clock,
  input  logic           reset,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam int MUL_EFF = (MUL_LAT < 1) ? 1 : MUL_LAT;
  localparam int DIV_EFF = (DIV_LAT < 1) ? 1 : DIV_LAT;
  localparam int LAT_MAX = (MUL_EFF > DIV_EFF) ? MUL_EFF : DIV_EFF;
  localparam int MDU_W   = $clog2(LAT_MAX + 1);
  localparam logic [MDU_W-1:0] MUL_LOAD = MDU_W'(MUL_EFF);
  localparam logic [MDU_W-1:0] DIV_LOAD = MDU_W'(DIV_EFF);

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_RUN,
    MDU_DONE
  } mdu_state_t;

  logic [CNT_W-1:0] cnt [32];
  logic [31:0]      inc_vec;
  logic [31:0]      dec_vec;
  logic [31:0]      busy;
  logic             raw_rs;
  logic             raw_rt;
  logic             waw_sat;
  logic             hilo_hz;
  logic             stall_c;
  logic             issue_c;
  logic             wb_orphan;
  logic             err_q;
  logic             mdu_load;

  mdu_state_t       state;
  mdu_state_t       state_nxt;
  logic [MDU_W-1:0] mdu_cnt;
  logic [MDU_W-1:0] mdu_cnt_nxt;

  function automatic logic reg_pending(input logic [4:0] r, input logic [CNT_W-1:0] c);
    return (r != 5'd0) && (c != '0);
  endfunction

  function automatic logic reg_saturated(input logic [4:0] r, input logic [CNT_W-1:0] c);
    return (r != 5'd0) && (c == CNT_SAT);
  endfunction

  // Hazard detection: no WB bypass, the register file commits on the edge
  always_comb begin
    raw_rs  = sb.id_use_rs && reg_pending(sb.id_rs, cnt[sb.id_rs]);
    raw_rt  = sb.id_use_rt && reg_pending(sb.id_rt, cnt[sb.id_rt]);
    waw_sat = sb.id_wen && reg_saturated(sb.id_waddr, cnt[sb.id_waddr]);
    hilo_hz = (sb.id_hilo_rd || sb.id_mdu_start) && (state == MDU_RUN);
    stall_c = sb.id_valid && (raw_rs || raw_rt || waw_sat || hilo_hz);
    issue_c = sb.id_valid && !stall_c;
  end

  always_comb begin
    inc_vec   = '0;
    dec_vec   = '0;
    wb_orphan = 1'b0;
    if (issue_c && sb.id_wen && (sb.id_waddr != 5'd0))
      inc_vec[sb.id_waddr] = 1'b1;
    if (sb.wb_wen && (sb.wb_waddr != 5'd0)) begin
      if (cnt[sb.wb_waddr] != '0)
        dec_vec[sb.wb_waddr] = 1'b1;
      else
        wb_orphan = 1'b1;
    end
  end

  // Counter stage: inc and dec on the same register cancel
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 32; r++)
        cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r])
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      err_q <= 1'b0;
    else if (wb_orphan)
      err_q <= 1'b1;
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++)
      busy[r] = (cnt[r] != '0);
  end

  assign mdu_load = issue_c && sb.id_mdu_start;

  // MDU sequencer: RUN holds HI/LO busy, DONE is the one-cycle completion pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= MDU_IDLE;
      mdu_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    case (state)
      MDU_IDLE, MDU_DONE: begin
        if (mdu_load) begin
          state_nxt   = MDU_RUN;
          mdu_cnt_nxt = sb.id_mdu_div ? DIV_LOAD : MUL_LOAD;
        end else begin
          state_nxt   = MDU_IDLE;
        end
      end
      MDU_RUN: begin
        if (mdu_cnt <= MDU_W'(1)) begin
          state_nxt   = MDU_DONE;
          mdu_cnt_nxt = '0;
        end else begin
          mdu_cnt_nxt = mdu_cnt - MDU_W'(1);
        end
      end
      default: begin
        state_nxt   = MDU_IDLE;
        mdu_cnt_nxt = '0;
      end
    endcase
  end

  assign sb.stall     = stall_c;
  assign sb.issue     = issue_c;
  assign sb.busy_vec  = busy;
  assign sb.hilo_busy = (state == MDU_RUN);
  assign sb.mdu_done  = (state == MDU_DONE);
  assign sb.sb_err    = err_q;

`ifdef SB_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] issue_count;

  // Statistics stage: free-running, wrap modulo 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, stall_c};
      issue_count  <= issue_count + {31'd0, issue_c};
    end
  end

  assign sb.stall_cycles = stall_cycles;
  assign sb.issue_count  = issue_count;
`endif

endmodule
